uart_cmd_ctrl: RTL

//  Byte-level command sequencer between the UART receiver/transmitter pair and the accelerator's
//  8-bit memory/register port. Parses host frames arriving from uart_rx, performs burst writes or

---
 rtl/uart_cmd_if.sv | 22 ++
 rtl/uart_cmd_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_cmd_if.sv
// uart_cmd_if: rx/tx byte handshake and 8-bit memory port seen by the command sequencer.
interface uart_cmd_if #(parameter int ADDR_W = 8);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              frame_err;
    modport master (
        input  rx_valid, rx_data, tx_busy, mem_rdata,
        output tx_start, tx_data, mem_we, mem_re, mem_addr, mem_wdata, frame_err
    );
    modport slave (
        output rx_valid, rx_data, tx_busy, mem_rdata,
        input  tx_start, tx_data, mem_we, mem_re, mem_addr, mem_wdata, frame_err
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses host frames from uart_rx, runs burst writes/reads on the memory
// port and feeds response bytes to uart_tx one at a time.
module uart_cmd_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          TIMEOUT_CYC = 2_000_000,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input logic       clk,
    input logic       rst,
    uart_cmd_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] GET_ADDR   = 4'd1;
    localparam logic [3:0] GET_LEN    = 4'd2;
    localparam logic [3:0] GET_DATA   = 4'd3;
    localparam logic [3:0] RD_ISSUE   = 4'd4;
    localparam logic [3:0] RD_CAPT    = 4'd5;
    localparam logic [3:0] TX_ISSUE   = 4'd6;
    localparam logic [3:0] TX_WAIT_HI = 4'd7;
    localparam logic [3:0] TX_WAIT_LO = 4'd8;

    logic [3:0]        state;
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        cnt;
    logic [TW-1:0]     tmo;
    logic              in_get;
    logic              expire;

    always_comb begin
        in_get = state == GET_ADDR || state == GET_LEN || state == GET_DATA;
        expire = in_get && !bus.rx_valid && tmo == TW'(TIMEOUT_CYC - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            is_wr         <= 1'b0;
            addr          <= '0;
            cnt           <= '0;
            tmo           <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.tx_start  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.frame_err <= 1'b0;
            tmo <= (in_get && !bus.rx_valid && !expire) ? tmo + 1'b1 : '0;
            case (state)
                IDLE: if (bus.rx_valid) begin
                    is_wr <= bus.rx_data == 8'h57;
                    cnt   <= '0;
                    if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) state <= GET_ADDR;
                    else begin
                        bus.tx_data <= NAK_BYTE;
                        state       <= TX_ISSUE;
                    end
                end
                GET_ADDR: if (bus.rx_valid) begin
                    addr  <= ADDR_W'(bus.rx_data);
                    state <= GET_LEN;
                end
                GET_LEN: if (bus.rx_valid) begin
                    cnt <= bus.rx_data;
                    if (is_wr && bus.rx_data == 8'd0) begin
                        bus.tx_data <= ACK_BYTE;
                        state       <= TX_ISSUE;
                    end else if (is_wr) state <= GET_DATA;
                    else if (bus.rx_data == 8'd0) state <= IDLE;
                    else begin
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= addr;
                        state        <= RD_ISSUE;
                    end
                end
                GET_DATA: if (bus.rx_valid) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= addr;
                    bus.mem_wdata <= bus.rx_data;
                    addr          <= addr + 1'b1;
                    cnt           <= cnt - 1'b1;
                    if (cnt == 8'd1) begin
                        bus.tx_data <= ACK_BYTE;
                        state       <= TX_ISSUE;
                    end
                end
                // mem_re was raised on entry, so read data is on the bus during RD_CAPT
                RD_ISSUE: state <= RD_CAPT;
                RD_CAPT: begin
                    bus.tx_data <= bus.mem_rdata;
                    addr        <= addr + 1'b1;
                    cnt         <= cnt - 1'b1;
                    state       <= TX_ISSUE;
                end
                TX_ISSUE: if (!bus.tx_busy) begin
                    bus.tx_start <= 1'b1;
                    state        <= TX_WAIT_HI;
                end
                TX_WAIT_HI: if (bus.tx_busy) state <= TX_WAIT_LO;
                TX_WAIT_LO: if (!bus.tx_busy) begin
                    if (!is_wr && cnt != 8'd0) begin
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= addr;
                        state        <= RD_ISSUE;
                    end else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (expire) begin
                bus.frame_err <= 1'b1;
                state         <= IDLE;
            end
        end
    end
endmodule
